// File: rtl/stage_memory.sv
// Memory stage: drives the data-memory handshake from the EX/MEM register and
// produces the MEM/WB register, stalling upstream while an access is outstanding.
module stage_memory #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_bus_error,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic [7:0]  count_next;
  logic        access;
  logic        misaligned;
  logic        aligned_access;
  logic        timeout_hit;
  logic        bubble;

  function automatic logic [31:0] select_result(input logic [1:0]  src,
                                                input logic [31:0] alu,
                                                input logic [31:0] rdata,
                                                input logic [31:0] pc4,
                                                input logic [31:0] imm);
    logic [31:0] res;
    unique case (src)
      2'b00:   res = alu;
      2'b01:   res = rdata;
      2'b10:   res = pc4;
      default: res = imm;
    endcase
    return res;
  endfunction

  assign access         = mem_mem_write | (mem_result_src == 2'b01);
  assign misaligned     = access & (mem_alu_result[1:0] != 2'b00);
  assign aligned_access = access & ~misaligned;

  // Watchdog fires on the cycle the counter reaches TIMEOUT with no ack yet.
  assign timeout_hit = (state == WAIT) & aligned_access & ~dmem_ack &
                       (count == TIMEOUT_CNT);

  assign dmem_req       = aligned_access & reset;
  assign dmem_we        = mem_mem_write;
  assign dmem_addr      = mem_alu_result;
  assign dmem_wdata     = mem_write_data;
  assign mem_stall      = dmem_req & ~dmem_ack & ~timeout_hit;
  assign mem_misaligned = misaligned & reset;
  assign mem_bus_error  = timeout_hit & reset;

  assign bubble = mem_stall | timeout_hit | misaligned;

  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (aligned_access && !dmem_ack) begin
          state_next = WAIT;
          count_next = 8'd1;
        end
      end
      WAIT: begin
        // Losing the access while waiting is treated like completion.
        if (!aligned_access || dmem_ack || timeout_hit) begin
          state_next = IDLE;
          count_next = 8'd0;
        end else begin
          count_next = count + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // MEM/WB register boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_result    <= 32'd0;
    end else if (wb_clear || bubble) begin
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_result    <= 32'd0;
    end else begin
      wb_reg_write <= mem_reg_write;
      wb_rd        <= mem_rd;
      wb_result    <= select_result(mem_result_src, mem_alu_result, dmem_rdata,
                                    mem_pc_plus_4, mem_imm_ext);
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios then random transactions, each
// checked against a transaction-level model of the access/stall/writeback rules.
module tb_stage_memory;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_clear = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic        mem_mem_write = 1'b0;
  logic [1:0]  mem_result_src = 2'b00;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_pc_plus_4 = '0;
  logic [31:0] mem_imm_ext = '0;
  logic [4:0]  mem_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        mem_stall;
  logic        mem_misaligned;
  logic        mem_bus_error;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int checks = 0;
  int errors = 0;

  stage_memory #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
    .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
    .mem_bus_error(mem_bus_error), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_result(wb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic [4:0] rd,
                        input logic [31:0] res);
    chk({tag, ".wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, rw});
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({tag, ".wb_result"}, wb_result, res);
  endtask

  // One instruction held at EX/MEM until it leaves the stage.
  // lat: ack on request cycle lat (>=1), or -1 for never. For non-memory or
  // misaligned instructions the single cycle carries ack = (lat == 1).
  // clr: request cycle on which wb_clear is raised (0 = never).
  task automatic run_txn(input string tag, input logic rw, input logic mw,
                         input logic [1:0] rs, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic [31:0] ack_data, input int lat, input int clr);
    logic        acc, mis, aligned, last_ok, ack_now;
    logic [31:0] exp_res, rdat;
    int          ncyc;
    acc     = mw | (rs == 2'b01);
    mis     = acc & (alu[1:0] != 2'b00);
    aligned = acc & ~mis;
    ncyc    = !aligned ? 1 : (lat < 0 ? TMO + 1 : lat);
    for (int c = 1; c <= ncyc; c++) begin
      ack_now = aligned ? (c == lat) : (lat == 1);
      rdat    = ack_now ? ack_data : $urandom;
      mem_reg_write  = rw;
      mem_mem_write  = mw;
      mem_result_src = rs;
      mem_alu_result = alu;
      mem_write_data = wd;
      mem_pc_plus_4  = pc4;
      mem_imm_ext    = imm;
      mem_rd         = rd;
      dmem_ack       = ack_now;
      dmem_rdata     = rdat;
      wb_clear       = (c == clr);
      @(negedge clk);
      chk({tag, ".req"}, {31'd0, dmem_req}, {31'd0, aligned});
      chk({tag, ".stall"}, {31'd0, mem_stall}, {31'd0, aligned && (c < ncyc || lat < 0) && c <= TMO});
      chk({tag, ".bus_error"}, {31'd0, mem_bus_error}, {31'd0, aligned && lat < 0 && c == TMO + 1});
      chk({tag, ".misaligned"}, {31'd0, mem_misaligned}, {31'd0, mis});
      chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, mw});
      chk({tag, ".addr"}, dmem_addr, alu);
      chk({tag, ".wdata"}, dmem_wdata, wd);
      @(posedge clk);
      #1;
      last_ok = (c == ncyc) && !(aligned && lat < 0) && !mis && (c != clr);
      case (rs)
        2'b00:   exp_res = alu;
        2'b01:   exp_res = ack_data;
        2'b10:   exp_res = pc4;
        default: exp_res = imm;
      endcase
      if (last_ok) chk_wb(tag, rw, rd, exp_res);
      else         chk_wb(tag, 1'b0, 5'd0, 32'd0);
    end
    wb_clear = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] addr;
    int          lat, clr, k;

    #2 reset = 1'b0;
    mem_result_src = 2'b01;
    mem_alu_result = 32'h40;
    mem_reg_write  = 1'b1;
    mem_rd         = 5'd7;
    #1;
    chk("reset.req", {31'd0, dmem_req}, 32'd0);
    chk("reset.stall", {31'd0, mem_stall}, 32'd0);
    chk("reset.bus_error", {31'd0, mem_bus_error}, 32'd0);
    chk_wb("reset", 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_wb("reset_edge", 1'b0, 5'd0, 32'd0);
    reset = 1'b1;

    run_txn("alu", 1'b1, 1'b0, 2'b00, 32'h1234, 32'h0, 32'h8, 32'h9, 5'd5, 32'h0, 0, 0);
    run_txn("load0", 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h8, 32'h9, 5'd3, 32'hDEADBEEF, 1, 0);
    run_txn("store3", 1'b0, 1'b1, 2'b00, 32'h200, 32'hA5A5A5A5, 32'h8, 32'h9, 5'd0, 32'h0, 4, 0);
    run_txn("misalign", 1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h8, 32'h9, 5'd4, 32'h0, 0, 0);
    run_txn("timeout", 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 32'h8, 32'h9, 5'd6, 32'h0, -1, 0);
    run_txn("late_ack", 1'b1, 1'b0, 2'b10, 32'h55, 32'h0, 32'h1008, 32'h9, 5'd8, 32'hBAD, 1, 0);
    run_txn("store_rw", 1'b1, 1'b1, 2'b11, 32'h404, 32'h77, 32'h8, 32'hCAFE, 5'd9, 32'h0, 2, 0);
    run_txn("clr_done", 1'b1, 1'b0, 2'b01, 32'h500, 32'h0, 32'h8, 32'h9, 5'd10, 32'h1111, 1, 1);
    run_txn("clr_wait", 1'b1, 1'b0, 2'b01, 32'h504, 32'h0, 32'h8, 32'h9, 5'd11, 32'h2222, 3, 1);

    mem_reg_write  = 1'b1;
    mem_mem_write  = 1'b0;
    mem_result_src = 2'b01;
    mem_alu_result = 32'h600;
    mem_rd         = 5'd12;
    dmem_ack       = 1'b0;
    @(negedge clk);
    chk("rst_wait.stall1", {31'd0, mem_stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wait.stall2", {31'd0, mem_stall}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_wait.req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wait.stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wait.bus_error", {31'd0, mem_bus_error}, 32'd0);
    chk_wb("rst_wait", 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold.req", {31'd0, dmem_req}, 32'd0);
    reset = 1'b1;
    run_txn("restart_to", 1'b1, 1'b0, 2'b01, 32'h600, 32'h0, 32'h8, 32'h9, 5'd12, 32'h0, -1, 0);
    run_txn("restart", 1'b1, 1'b0, 2'b01, 32'h600, 32'h0, 32'h8, 32'h9, 5'd12, 32'h3333, 2, 0);

    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 4);
      mw = (k == 2);
      case (k)
        0:       rs = 2'b00;
        1:       rs = 2'b01;
        2:       rs = 2'($urandom_range(0, 3));
        3:       rs = 2'b10;
        default: rs = 2'b11;
      endcase
      addr = $urandom;
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      else                           addr[1:0] = 2'b00;
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, 4);
      clr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      run_txn("rand", 1'($urandom_range(0, 1)), mw, rs, addr, $urandom, $urandom,
              $urandom, 5'($urandom_range(0, 31)), $urandom, lat, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory stage of the five-stage core: consumes the EX/MEM pipeline register driven by the execute stage. Runs the load/store handshake with data memory and produces the MEM/WB register: selected result, destination register, write enable. Requests a stall from the hazard unit while an access waits on memory. Aborts an access that never acknowledges, using a watchdog.

## Interface
- TIMEOUT, 64: maximum wait cycles for `dmem_ack` before abort; valid range 1..255.
- clk  in  1  core clock; all flops on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- wb_clear  in  1  synchronous flush of the MEM/WB register.
- mem_reg_write  in  1  instruction writes rd.
- mem_mem_write  in  1  instruction is a store.
- mem_result_src  in  2  00 ALU, 01 load data, 10 pc+4, 11 imm_ext.
- mem_alu_result  in  32  effective address / ALU result.
- mem_write_data  in  32  store data.
- mem_pc_plus_4  in  32  link value.
- mem_imm_ext  in  32  immediate.
- mem_rd  in  5  destination register.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when `dmem_ack`=1.
- dmem_ack  in  1  access complete.
- mem_stall  out  1  to hazard unit: hold PC, IF/ID, ID/EX, EX/MEM.
- mem_misaligned  out  1  one-cycle pulse: access with addr[1:0]≠0 dropped.
- mem_bus_error  out  1  one-cycle pulse: watchdog abort.
- wb_reg_write  out  1  registered write enable.
- wb_rd  out  5  registered destination.
- wb_result  out  32  registered writeback value; also forwarded to execute.

## Operation
- An access is present when `mem_mem_write`=1 or `mem_result_src`=01.
- Misaligned access (addr[1:0]≠0):
  - no request is issued;
  - `mem_misaligned` pulses;
  - the MEM/WB register takes a bubble.
- Request outputs are combinational from state and inputs:
  - `dmem_req` = aligned access present, state IDLE or WAIT, reset deasserted.
  - `dmem_we` = `mem_mem_write`.
  - `dmem_addr` = `mem_alu_result`.
  - `dmem_wdata` = `mem_write_data`.
- `mem_stall` = `dmem_req` & ~`dmem_ack` & ~timeout_hit. Upstream holds the EX/MEM inputs stable while stalled.
- FSM states: IDLE, WAIT.
  - IDLE, aligned access, ack=1: zero-wait completion; stay IDLE.
  - IDLE, aligned access, ack=0: go to WAIT; counter ← 1.
  - WAIT, ack=1: completion; go to IDLE.
  - WAIT, ack=0, counter=TIMEOUT: abort; `mem_bus_error` pulses; bubble; go to IDLE; stall releases that cycle.
  - WAIT, otherwise: counter+1.
- MEM/WB update, in priority order:
  - wb_clear: all zero.
  - Stall, abort, or misaligned: bubble (`wb_reg_write`←0, `wb_rd`←0, `wb_result`←0).
  - Otherwise: `wb_reg_write`←`mem_reg_write`, `wb_rd`←`mem_rd`, `wb_result`← source selected by `mem_result_src` (load selects `dmem_rdata`).
- Stores with `mem_reg_write`=1 are legal; `wb_result` takes the source selected by `mem_result_src`.

## Timing
- Reset asserted: state IDLE, counter 0, `dmem_req`=0, `mem_stall`=0, all `wb_*`=0, error pulses 0. Applies immediately, including mid-WAIT; the bus transaction is abandoned.
- Non-memory instruction: one cycle, result at `wb_*` on the next edge.
- Load/store with ack on cycle N of request (N≥1): stall for N−1 cycles. `wb_*` update on the edge ending cycle N.
- Abort: request held TIMEOUT+1 cycles, then a bubble. A late ack after abort, arriving while IDLE with no access present, is ignored.
- `wb_clear` during a completing access: the result is discarded, the access still completes, no stall.
- `wb_clear` during WAIT: the FSM is unaffected.

## Test plan
- ALU op: result_src=00, alu_result=0x1234, rd=5, reg_write=1 → next edge wb_result=0x1234, wb_rd=5, wb_reg_write=1, no stall.
- Zero-wait load: addr=0x100, ack same cycle, rdata=0xDEADBEEF → stall never asserted; next edge wb_result=0xDEADBEEF.
- Store with 3 wait cycles: addr=0x200, wdata=0xA5A5A5A5:
  - ack on 4th request cycle → dmem_we=1 and stall for 3 cycles;
  - bubbles meanwhile;
  - wb_reg_write=0 after.
- Misaligned load, addr=0x102 → dmem_req=0, mem_misaligned 1-cycle pulse, bubble, no stall.
- Timeout, TIMEOUT=4, ack never → stall for 4 cycles, release on 5th with mem_bus_error pulse; FSM IDLE.
- Reset deasserted→asserted mid-WAIT → dmem_req and mem_stall drop immediately, wb_* zero. After release, a pending load restarts from IDLE.
